// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Runs a PWM "breathing" brightness envelope and sequences it across
//   N_LED outputs. The envelope ramps the duty from DUTY_MIN up to DUTY_MAX
//   and back down, advancing by one step every STEP_CYCLES clocks.
//   Modes: 0 off, 1 all LEDs breathe in unison, 2 single-LED chase,
//   3 ping-pong chase.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous reset, active-high
//   en          in   1 = run; 0 = freeze sequencing with LEDs dark
//   mode[1:0]   in   pattern select, sampled only on mode_load
//   mode_load   in   1-cycle pulse: latch mode and restart the pattern
//   led_out     out  registered LED drive, 1 = on
//   active_ch   out  channel currently breathing (0 in modes 0/1)
//   cycle_done  out  1-cycle pulse at the end of each full pattern cycle
module led_pattern_sequencer #(
  parameter int N_LED       = 8,
  parameter int PWM_PERIOD  = 100,
  parameter int STEP_CYCLES = 5000000,
  parameter int DUTY_MIN    = 1,
  parameter int DUTY_MAX    = 50,
  localparam int CH_W       = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             mode_load,
  output logic [N_LED-1:0] led_out,
  output logic [CH_W-1:0]  active_ch,
  output logic             cycle_done
);

  // pwm_cnt shares the duty width so the compare needs no extension.
  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [DUTY_W-1:0] PWM_LAST   = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DUTY_MIN_V = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(N_LED - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    ADVANCE   = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          mode_reg;
  logic [DUTY_W-1:0]   duty;
  logic [DUTY_W-1:0]   pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [CH_W-1:0]     ch;
  logic                dir_up;

  logic                step_tick;
  logic                on_p0;
  logic [N_LED-1:0]    led_nxt;
  logic [CH_W-1:0]     ch_nxt;
  logic                dir_nxt;
  logic                wrap_nxt;

  assign step_tick = en && (step_cnt == STEP_LAST);
  assign active_ch = ch;

  // Stage 0: PWM compare and per-channel gating, registered into led_out.
  assign on_p0 = (pwm_cnt < duty);

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (mode_reg == 2'd1)
        led_nxt[i] = on_p0;
      else if (mode_reg[1])
        led_nxt[i] = on_p0 && (ch == CH_W'(i));
    end
  end

  // Next channel taken on leaving ADVANCE. wrap_nxt marks the end of a full
  // pattern cycle (back at channel 0).
  always_comb begin
    ch_nxt   = ch;
    dir_nxt  = dir_up;
    wrap_nxt = 1'b0;
    if (N_LED == 1) begin
      ch_nxt   = '0;
      wrap_nxt = 1'b1;
    end else if (mode_reg == 2'd2) begin
      if (ch == CH_LAST) begin
        ch_nxt   = '0;
        wrap_nxt = 1'b1;
      end else begin
        ch_nxt = ch + CH_W'(1);
      end
    end else begin
      // Ping-pong: bounce off the ends, reversing direction there.
      if (dir_up) begin
        if (ch == CH_LAST) begin
          dir_nxt = 1'b0;
          ch_nxt  = ch - CH_W'(1);
        end else begin
          ch_nxt = ch + CH_W'(1);
        end
      end else begin
        if (ch == '0) begin
          dir_nxt = 1'b1;
          ch_nxt  = ch + CH_W'(1);
        end else begin
          ch_nxt = ch - CH_W'(1);
        end
      end
      wrap_nxt = (ch_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg   <= 2'd0;
      state      <= IDLE;
      duty       <= '0;
      step_cnt   <= '0;
      pwm_cnt    <= '0;
      ch         <= '0;
      dir_up     <= 1'b1;
      led_out    <= '0;
      cycle_done <= 1'b0;
    end else if (mode_load) begin
      // A load wins over any coincident tick or ADVANCE.
      mode_reg   <= mode;
      state      <= IDLE;
      duty       <= '0;
      step_cnt   <= '0;
      pwm_cnt    <= '0;
      ch         <= '0;
      dir_up     <= 1'b1;
      led_out    <= '0;
      cycle_done <= 1'b0;
    end else if (!en) begin
      // Freeze everything except the outputs, which go dark.
      led_out    <= '0;
      cycle_done <= 1'b0;
    end else begin
      led_out    <= led_nxt;
      cycle_done <= 1'b0;

      // Counters run in every active state, held at zero in IDLE.
      if (state != IDLE) begin
        pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + DUTY_W'(1);
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_W'(1);
      end

      case (state)
        IDLE: begin
          if (mode_reg != 2'd0) begin
            state <= RAMP_UP;
            duty  <= DUTY_MIN_V;
          end
        end
        RAMP_UP: begin
          if (step_tick) begin
            if (duty < DUTY_MAX_V)
              duty <= duty + DUTY_W'(1);
            else
              state <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (step_tick) begin
            if (duty > DUTY_MIN_V) begin
              duty <= duty - DUTY_W'(1);
            end else if (mode_reg == 2'd1) begin
              state      <= RAMP_UP;
              cycle_done <= 1'b1;
            end else begin
              state <= ADVANCE;
            end
          end
        end
        ADVANCE: begin
          ch         <= ch_nxt;
          dir_up     <= dir_nxt;
          cycle_done <= wrap_nxt;
          state      <= RAMP_UP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with N_LED=4, PWM_PERIOD=10,
//   STEP_CYCLES=4, DUTY_MIN=1, DUTY_MAX=5.
//
//   Expected values come from closed-form timelines counted from the edge
//   that samples mode_load (edge 0):
//     edge 1 leaves IDLE with duty 1; from edge 2 on the PWM counter seen
//     before edge k is (k-2)%10 and the envelope index is (k-2)/4, so the
//     duty before edge k is SEQ[((k-2)/4)%10].
//     Each channel lasts 40 cycles; ADVANCE edges are k = 2 + 40*n.
//     mode1 cycle_done after edges 41, 81, ...; mode2 after 162 (3->0);
//     mode3 after 242 (arrival back at 0).
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       mode_load = 1'b0;
  logic [3:0] led_out;
  logic [1:0] active_ch;
  logic       cycle_done;

  int total = 0;
  int bad   = 0;

  int seq [10] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};
  int pp  [6]  = '{0, 1, 2, 3, 2, 1};

  led_pattern_sequencer #(
    .N_LED(4), .PWM_PERIOD(10), .STEP_CYCLES(4), .DUTY_MIN(1), .DUTY_MAX(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .mode_load(mode_load),
    .led_out(led_out), .active_ch(active_ch), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  function automatic int ch_after(int k, int m);
    int n;
    if (m < 2 || k < 2) return 0;
    n = (k - 2) / 40;
    if (m == 2) return n % 4;
    return pp[n % 6];
  endfunction

  function automatic int exp_led(int k, int m);
    int p, d;
    if (m == 0 || k < 2) return 0;
    p = (k - 2) % 10;
    d = seq[((k - 2) / 4) % 10];
    if (p >= d) return 0;
    if (m == 1) return 15;
    return 1 << ch_after(k - 1, m);
  endfunction

  function automatic int exp_done(int k, int m);
    if (m == 1) return (k >= 41 && (k - 1) % 40 == 0) ? 1 : 0;
    if (m == 2) return (k >= 42 && (k - 2) % 160 == 0) ? 1 : 0;
    if (m == 3) return (k >= 42 && (k - 2) % 240 == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic cmp(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s k=%0d got=%0h want=%0h", tag, k, got, want);
    end
  endtask

  task automatic chk(input string tag, input int k, input int m);
    cmp({tag, "/led"}, k, 32'(led_out), 32'(exp_led(k, m)));
    cmp({tag, "/ch"}, k, 32'(active_ch), 32'(ch_after(k, m)));
    cmp({tag, "/done"}, k, 32'(cycle_done), 32'(exp_done(k, m)));
  endtask

  task automatic load(input int m);
    mode = 2'(m);
    mode_load = 1'b1;
    @(posedge clk); #1;
    mode_load = 1'b0;
  endtask

  // Advance edges k0..k1; the model is evaluated at k-off.
  task automatic run(input string tag, input int m, input int k0, input int k1,
                     input int off);
    for (int k = k0; k <= k1; k++) begin
      @(posedge clk); #1;
      chk(tag, k - off, m);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("rst/led", 0, 32'(led_out), 32'd0);
    cmp("rst/ch", 0, 32'(active_ch), 32'd0);
    cmp("rst/done", 0, 32'(cycle_done), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Chase into channel 1 RAMP_UP, then assert reset between edges
    load(2);
    chk("pre_rst", 0, 2);
    run("pre_rst", 2, 1, 52, 0);
    cmp("pre_rst/lit", 52, 32'(led_out), 32'h2);
    #3 rst = 1'b1;
    #1;
    cmp("arst/led", 52, 32'(led_out), 32'd0);
    cmp("arst/ch", 52, 32'(active_ch), 32'd0);
    cmp("arst/done", 52, 32'(cycle_done), 32'd0);
    #1 rst = 1'b0;

    // Unison breathe, restarting from duty 1
    load(1);
    chk("unison", 0, 1);
    run("unison", 1, 1, 90, 0);

    // Single chase
    load(2);
    chk("chase", 0, 2);
    run("chase", 2, 1, 170, 0);

    // Ping-pong chase
    load(3);
    chk("pong", 0, 3);
    run("pong", 3, 1, 330, 0);

    // Freeze for 50 cycles mid RAMP_DOWN on channel 1, then resume
    load(2);
    chk("frz_pre", 0, 2);
    run("frz_pre", 2, 1, 64, 0);
    en = 1'b0;
    for (int k = 65; k <= 114; k++) begin
      @(posedge clk); #1;
      cmp("frz/led", k, 32'(led_out), 32'd0);
      cmp("frz/ch", k, 32'(active_ch), 32'(ch_after(64, 2)));
      cmp("frz/done", k, 32'(cycle_done), 32'd0);
    end
    en = 1'b1;
    run("frz_post", 2, 115, 160, 50);

    // Load mode0 on the RAMP_DOWN tick that would pulse cycle_done
    load(1);
    chk("ld0_pre", 0, 1);
    run("ld0_pre", 1, 1, 40, 0);
    load(0);
    chk("ld0", 41, 0);
    run("ld0_idle", 0, 42, 61, 0);
    load(2);
    chk("ld0_restart", 0, 2);
    run("ld0_restart", 2, 1, 50, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
